// File: rtl/seg_dec_pkg.sv
// Shared types and constants for the seven-segment display-bus monitor.
package seg_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int SEG_W   = 8;
    localparam int LED_W   = 8;
    localparam int VALUE_W = 6;
    localparam int CNT_W   = 8;

    localparam logic [SEG_W-1:0] SEG_M4      = 8'b11100110;
    localparam logic [SEG_W-1:0] SEG_M3      = 8'b11001111;
    localparam logic [SEG_W-1:0] SEG_M2      = 8'b11011011;
    localparam logic [SEG_W-1:0] SEG_M1      = 8'b10000110;
    localparam logic [SEG_W-1:0] SEG_P0      = 8'b00111111;
    localparam logic [SEG_W-1:0] SEG_P1      = 8'b00000110;
    localparam logic [SEG_W-1:0] SEG_P2      = 8'b01011011;
    localparam logic [SEG_W-1:0] SEG_P3      = 8'b01001111;
    localparam logic [SEG_W-1:0] SEG_PRODUCT = 8'b10000000;

endpackage

// File: rtl/seg_led_decoder_seg7_to_int.sv
// Combinational seven-segment pattern decoder: pattern -> {legal, product, signed 3-bit value}.
module seg7_to_int
    import seg_dec_pkg::*;
(
    input  logic [SEG_W-1:0]  seg,
    output logic              legal,
    output logic              product,
    output logic signed [2:0] value
);

    always_comb begin
        legal   = 1'b1;
        product = 1'b0;
        value   = 3'b000;
        case (seg)
            SEG_M4:      value = 3'b100;
            SEG_M3:      value = 3'b101;
            SEG_M2:      value = 3'b110;
            SEG_M1:      value = 3'b111;
            SEG_P0:      value = 3'b000;
            SEG_P1:      value = 3'b001;
            SEG_P2:      value = 3'b010;
            SEG_P3:      value = 3'b011;
            SEG_PRODUCT: product = 1'b1;
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_led_decoder.sv
// Display-bus monitor: debounces {seg,led}, decodes sum/product results, counts illegal patterns.
// Optional SEG_DEC_MISMATCH_EN adds a 'mismatch' output comparing the LED field with the decoded sum.
module seg_led_decoder
    import seg_dec_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_BITS  = 8
) (
    input  logic                      clk_2,
    input  logic                      reset,
    input  logic [SEG_W-1:0]          seg_in,
    input  logic [LED_W-1:0]          led_in,
    output logic signed [VALUE_W-1:0] value,
    output logic                      value_valid,
    output logic                      is_product,
    output logic                      ovf,
    output logic                      decode_err,
    output logic [ERR_CNT_BITS-1:0]   err_count
`ifdef SEG_DEC_MISMATCH_EN
    ,
    output logic                      mismatch
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t                      state_q, state_d;
    logic [SEG_W+LED_W-1:0]      s_q, s_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [VALUE_W-1:0]   value_q, value_d;
    logic                        valid_q, valid_d;
    logic                        product_q, product_d;
    logic                        ovf_q, ovf_d;
    logic                        err_q, err_d;
    logic [ERR_CNT_BITS-1:0]     err_cnt_q, err_cnt_d;
    logic                        mism_q, mism_d;

    logic                        dec_legal;
    logic                        dec_product;
    logic signed [2:0]           dec_value;
    logic [SEG_W+LED_W-1:0]      sample;
    logic                        changed;

    // Decoder always looks at the held sample, so an accept uses exactly what was debounced.
    seg7_to_int u_seg7_to_int (
        .seg     (s_q[SEG_W+LED_W-1:LED_W]),
        .legal   (dec_legal),
        .product (dec_product),
        .value   (dec_value)
    );

    assign sample  = {seg_in, led_in};
    assign changed = (sample != s_q) || (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        product_d = product_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        mism_d    = mism_q;

        if (changed) begin
            s_d     = sample;
            cnt_d   = '0;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = LOCKED;
                valid_d   = 1'b1;
                product_d = dec_product;
                ovf_d     = s_q[7];
                err_d     = ~dec_legal;
                mism_d    = 1'b0;
                if (dec_product) begin
                    value_d = s_q[5:0];
                end else if (dec_legal) begin
                    value_d = {{(VALUE_W-3){dec_value[2]}}, dec_value};
                    mism_d  = (s_q[2:0] != dec_value) || (s_q[5:3] != 3'b000);
                end else begin
                    value_d = '0;
                    if (err_cnt_q != '1)
                        err_cnt_d = err_cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            product_q <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            mism_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            mism_q    <= mism_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign is_product  = product_q;
    assign ovf         = ovf_q;
    assign decode_err  = err_q;
    assign err_count   = err_cnt_q;

`ifdef SEG_DEC_MISMATCH_EN
    assign mismatch = mism_q;
`else
    logic unused_mism;
    assign unused_mism = mism_q;
`endif

endmodule
